// File: rtl/regfile_wb_ctrl_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl_if
//   Writeback request channel from the execute/memory stage to the
//   register-file writeback controller.
//
//   Signals:
//     wb_valid  request valid (master -> slave)
//     wb_ready  slave can accept the request (slave -> master)
//     wb_rd     destination GPR index
//     wb_data   result data, or jump target when wb_jump=1
//     wb_jump   entry is a PC update rather than a GPR write
//
//   Modports:
//     master  the producer of results (execute/memory stage, testbench)
//     slave   the writeback controller
// ---------------------------------------------------------------------------
interface regfile_wb_ctrl_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_jump;

  modport master (output wb_valid, output wb_rd, output wb_data,
                  output wb_jump, input wb_ready);
  modport slave  (input wb_valid, input wb_rd, input wb_data,
                  input wb_jump, output wb_ready);
endinterface

// File: rtl/regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl
//   Writeback-side initiator for the CPU register file. Completed results
//   arrive over a valid/ready channel and are queued in a DEPTH-entry FIFO.
//   One entry per cycle is drained into the register-file write port. A
//   pending-write scoreboard lets decode stall on RAW hazards, and the PC is
//   frozen while a jump is still waiting in the queue.
//
//   Ports:
//     clk, rst_n      clock (rising edge) / asynchronous active-low reset
//     halt            CPU halted: no drain, pushes still accepted
//     wb              writeback request channel (slave modport)
//     rs1_query       decode rs1 index  -> rs1_busy
//     rs2_query       decode rs2 index  -> rs2_busy
//     reg_rd_wrn      0 = GPR write this cycle, 1 = read/idle
//     rd_reg_offset   GPR write index
//     reg_data_in     write data / new PC
//     update_pc       load PC from reg_data_in this cycle
//     freeze_pc       hold PC (no increment)
//     fifo_level      current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module regfile_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               halt,
  regfile_wb_ctrl_if.slave   wb,
  input  logic [4:0]         rs1_query,
  input  logic [4:0]         rs2_query,
  output logic               rs1_busy,
  output logic               rs2_busy,
  output logic               reg_rd_wrn,
  output logic [4:0]         rd_reg_offset,
  output logic [31:0]        reg_data_in,
  output logic               update_pc,
  output logic               freeze_pc,
  output logic [PTR_W:0]     fifo_level
);

  // Queue storage, split per field.
  logic [31:0]      mem_data [DEPTH];
  logic [4:0]       mem_rd   [DEPTH];
  logic             mem_jump [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   level;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Ready depends only on registered occupancy, never on this cycle's pop,
  // so a full queue frees its slot one cycle after the pop.
  assign full     = (level == (PTR_W+1)'(DEPTH));
  assign empty    = (level == '0);
  assign push     = wb.wb_valid && !full;
  assign pop      = !empty && !halt;
  assign wb.wb_ready = !full;
  assign fifo_level  = level;

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity comes solely from the
  // head pointer and occupancy, so stale contents are never observed and
  // the array can map onto plain registers or a small RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[tail] <= wb.wb_data;
      mem_rd[tail]   <= wb.wb_rd;
      mem_jump[tail] <= wb.wb_jump;
    end
  end

  // Register-file write port, driven straight from the head entry.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    reg_rd_wrn    = 1'b1;
    rd_reg_offset = '0;
    reg_data_in   = '0;
    update_pc     = 1'b0;
    if (pop) begin
      reg_data_in = mem_data[head];
      if (mem_jump[head]) begin
        update_pc = 1'b1;
      end else if (mem_rd[head] != 5'd0) begin
        // Writes to x0 are drained but never reach the register file.
        reg_rd_wrn    = 1'b0;
        rd_reg_offset = mem_rd[head];
      end
    end
  end

  // Scoreboard and PC freeze, evaluated over all currently valid entries.
  // The head stays in the scoreboard even in the cycle it is popped, so
  // decode may stall one cycle longer than strictly required.
  logic             jump_waiting;
  logic [PTR_W-1:0] slot_offset;
  logic             slot_valid;

  always_comb begin
    rs1_busy     = 1'b0;
    rs2_busy     = 1'b0;
    jump_waiting = 1'b0;
    slot_offset  = '0;
    slot_valid   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      // Distance from head, modulo DEPTH, tells whether slot i is occupied.
      slot_offset = PTR_W'(i) - head;
      slot_valid  = ({1'b0, slot_offset} < level);
      if (slot_valid && !mem_jump[i]) begin
        if (rs1_query != 5'd0 && mem_rd[i] == rs1_query) rs1_busy = 1'b1;
        if (rs2_query != 5'd0 && mem_rd[i] == rs2_query) rs2_busy = 1'b1;
      end
      // A jump being applied this cycle no longer holds the PC.
      if (slot_valid && mem_jump[i] && !(pop && PTR_W'(i) == head))
        jump_waiting = 1'b1;
    end
  end

  assign freeze_pc = (jump_waiting || full) && !update_pc;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_ctrl
//   Directed self-checking bench for regfile_wb_ctrl. Inputs change on the
//   falling edge; outputs are checked 1 ns later, well away from the rising
//   edge where the DUT updates.
// ---------------------------------------------------------------------------
module tb_regfile_wb_ctrl;

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic [4:0]  rs1_query;
  logic [4:0]  rs2_query;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        reg_rd_wrn;
  logic [4:0]  rd_reg_offset;
  logic [31:0] reg_data_in;
  logic        update_pc;
  logic        freeze_pc;
  logic [2:0]  fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_ctrl_if wb ();

  regfile_wb_ctrl #(.DEPTH(4), .PTR_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .halt          (halt),
    .wb            (wb.slave),
    .rs1_query     (rs1_query),
    .rs2_query     (rs2_query),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .reg_rd_wrn    (reg_rd_wrn),
    .rd_reg_offset (rd_reg_offset),
    .reg_data_in   (reg_data_in),
    .update_pc     (update_pc),
    .freeze_pc     (freeze_pc),
    .fifo_level    (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then back to the falling edge to drive new inputs.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic v, input logic [4:0] rd,
                         input logic [31:0] d, input logic j);
    wb.wb_valid = v;
    wb.wb_rd    = rd;
    wb.wb_data  = d;
    wb.wb_jump  = j;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_wrn"},   {31'd0, reg_rd_wrn}, 32'd1);
    check({tag, "_upd"},   {31'd0, update_pc},  32'd0);
    check({tag, "_data"},  reg_data_in,         32'd0);
    check({tag, "_off"},   {27'd0, rd_reg_offset}, 32'd0);
  endtask

  initial begin
    // ---------------- Reset with random inputs ----------------
    rst_n     = 1'b0;
    halt      = 1'($urandom);
    rs1_query = 5'($urandom);
    rs2_query = 5'($urandom);
    set_req(1'b1, 5'($urandom), $urandom, 1'($urandom));
    repeat (3) tick();
    #1;
    check_idle("rst");
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_ready", {31'd0, wb.wb_ready}, 32'd1);
    check("rst_frz",   {31'd0, freeze_pc}, 32'd0);
    check("rst_b1",    {31'd0, rs1_busy}, 32'd0);
    check("rst_b2",    {31'd0, rs2_busy}, 32'd0);

    set_req(1'b0, 5'd0, 32'd0, 1'b0);
    halt = 1'b0; rs1_query = 5'd0; rs2_query = 5'd0;
    rst_n = 1'b1;
    tick();
    #1;
    check("rel_ready", {31'd0, wb.wb_ready}, 32'd1);
    check("rel_wrn",   {31'd0, reg_rd_wrn}, 32'd1);

    // ---------------- Single write, then push+pop together ----------------
    rs1_query = 5'd5;
    set_req(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    tick();
    set_req(1'b1, 5'd6, 32'h66, 1'b0);
    #1;
    check("sw_wrn",  {31'd0, reg_rd_wrn}, 32'd0);
    check("sw_off",  {27'd0, rd_reg_offset}, 32'd5);
    check("sw_data", reg_data_in, 32'hDEADBEEF);
    check("sw_busy", {31'd0, rs1_busy}, 32'd1);
    check("sw_lvl",  {29'd0, fifo_level}, 32'd1);
    tick();
    set_req(1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    check("pp_lvl",  {29'd0, fifo_level}, 32'd1);
    check("pp_busy", {31'd0, rs1_busy}, 32'd0);
    check("pp_off",  {27'd0, rd_reg_offset}, 32'd6);
    check("pp_data", reg_data_in, 32'h66);
    tick();
    #1;
    check("sw_empty", {29'd0, fifo_level}, 32'd0);
    check_idle("sw_idle");

    // ---------------- Fill under halt, backpressure ----------------
    halt = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      set_req(1'b1, 5'(r), 32'h100 + r, 1'b0);
      tick();
    end
    rs2_query = 5'd3;
    rs1_query = 5'd9;
    #1;
    check("fill_lvl",   {29'd0, fifo_level}, 32'd4);
    check("fill_ready", {31'd0, wb.wb_ready}, 32'd0);
    check("fill_frz",   {31'd0, freeze_pc}, 32'd1);
    check("fill_b2",    {31'd0, rs2_busy}, 32'd1);
    check_idle("fill_halt");
    set_req(1'b1, 5'd9, 32'h999, 1'b0);   // dropped: queue is full
    tick();
    set_req(1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    check("drop_lvl", {29'd0, fifo_level}, 32'd4);
    check("drop_b1",  {31'd0, rs1_busy}, 32'd0);
    halt = 1'b0;
    #1;
    check("full_pop_ready", {31'd0, wb.wb_ready}, 32'd0);
    for (int r = 1; r <= 4; r++) begin
      check($sformatf("drain%0d_wrn", r),  {31'd0, reg_rd_wrn}, 32'd0);
      check($sformatf("drain%0d_off", r),  {27'd0, rd_reg_offset}, 32'(r));
      check($sformatf("drain%0d_data", r), reg_data_in, 32'h100 + 32'(r));
      tick();
      #1;
    end
    check("drain_lvl", {29'd0, fifo_level}, 32'd0);
    check_idle("drain_idle");

    // ---------------- Jump ordering ----------------
    halt = 1'b1;
    rs1_query = 5'd7;
    set_req(1'b1, 5'd1, 32'h10, 1'b0);
    tick();
    set_req(1'b1, 5'd7, 32'h40, 1'b1);
    tick();
    set_req(1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    check("jq_frz",  {31'd0, freeze_pc}, 32'd1);
    check("jq_b1",   {31'd0, rs1_busy}, 32'd0);
    check("jq_lvl",  {29'd0, fifo_level}, 32'd2);
    halt = 1'b0;
    #1;
    check("j1_wrn",  {31'd0, reg_rd_wrn}, 32'd0);
    check("j1_off",  {27'd0, rd_reg_offset}, 32'd1);
    check("j1_data", reg_data_in, 32'h10);
    check("j1_frz",  {31'd0, freeze_pc}, 32'd1);
    tick();
    #1;
    check("j2_upd",  {31'd0, update_pc}, 32'd1);
    check("j2_data", reg_data_in, 32'h40);
    check("j2_wrn",  {31'd0, reg_rd_wrn}, 32'd1);
    check("j2_off",  {27'd0, rd_reg_offset}, 32'd0);
    check("j2_frz",  {31'd0, freeze_pc}, 32'd0);
    tick();
    #1;
    check_idle("j_idle");
    check("j_idle_frz", {31'd0, freeze_pc}, 32'd0);

    // ---------------- x0 handling ----------------
    rs1_query = 5'd0;
    rs2_query = 5'd0;
    set_req(1'b1, 5'd0, 32'h1234, 1'b0);
    tick();
    set_req(1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    check("x0_lvl", {29'd0, fifo_level}, 32'd1);
    check("x0_b1",  {31'd0, rs1_busy}, 32'd0);
    check("x0_b2",  {31'd0, rs2_busy}, 32'd0);
    check("x0_wrn", {31'd0, reg_rd_wrn}, 32'd1);
    check("x0_upd", {31'd0, update_pc}, 32'd0);
    tick();
    #1;
    check("x0_empty", {29'd0, fifo_level}, 32'd0);

    // ---------------- Reset mid-operation ----------------
    halt = 1'b1;
    for (int r = 10; r <= 12; r++) begin
      set_req(1'b1, 5'(r), 32'h200 + r, 1'b0);
      tick();
    end
    set_req(1'b0, 5'd0, 32'd0, 1'b0);
    halt = 1'b0;
    rs1_query = 5'd11;
    #1;
    check("mr_lvl",  {29'd0, fifo_level}, 32'd3);
    check("mr_off",  {27'd0, rd_reg_offset}, 32'd10);
    check("mr_b1",   {31'd0, rs1_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_rst_lvl", {29'd0, fifo_level}, 32'd0);
    check_idle("mr_rst");
    check("mr_rst_b1", {31'd0, rs1_busy}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      check($sformatf("mr_after%0d_wrn", k), {31'd0, reg_rd_wrn}, 32'd1);
      check($sformatf("mr_after%0d_lvl", k), {29'd0, fifo_level}, 32'd0);
    end
    check("mr_ready", {31'd0, wb.wb_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
